// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the memory stage and a single-port word-wide data memory.
// Sub-word stores are done as read-modify-write; misaligned/illegal requests fault without a memory access.
module lsu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic            o_resp_fault,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam int OW = $clog2(XLEN / 8);
  localparam int SW = OW + 3;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t          r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [OW-1:0]   r_off;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_load_data;
  logic            r_fault;

  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_fault;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;

  logic            w_misaligned;
  logic            w_illegal;
  logic            w_full_store;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_size_mask;
  logic [XLEN-1:0] w_lane_mask;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_merged;
  logic            w_sign;

  always_comb begin
    w_misaligned = 1'b0;
    case (i_req_funct3[1:0])
      2'd1:    w_misaligned = i_req_addr[0];
      2'd2:    w_misaligned = |i_req_addr[1:0];
      2'd3:    w_misaligned = |i_req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
    if (i_req_we)
      w_illegal = i_req_funct3[2] || (XLEN == 32 && i_req_funct3[1:0] == 2'd3);
    else
      w_illegal = (i_req_funct3 == 3'b111) ||
                  (XLEN == 32 && (i_req_funct3 == 3'b011 || i_req_funct3 == 3'b110));
    w_full_store = i_req_we && (i_req_funct3 == ((XLEN == 64) ? 3'b011 : 3'b010));
  end

  // The same size mask serves load extraction and store merging (funct3[1:0] encodes size for both).
  always_comb begin
    w_shamt     = {r_off, 3'b000};
    w_shifted   = i_mem_rdata >> w_shamt;
    w_size_mask = '1;
    w_sign      = 1'b0;
    case (r_funct3[1:0])
      2'd0: begin w_size_mask = XLEN'(8'hFF);         w_sign = w_shifted[7];  end
      2'd1: begin w_size_mask = XLEN'(16'hFFFF);      w_sign = w_shifted[15]; end
      2'd2: begin w_size_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_shifted[31]; end
      default: begin w_size_mask = '1;                w_sign = 1'b0;          end
    endcase
    w_sign      = w_sign & ~r_funct3[2];
    w_load_data = (w_shifted & w_size_mask) | ({XLEN{w_sign}} & ~w_size_mask);
    w_lane_mask = w_size_mask << w_shamt;
    w_merged    = (i_mem_rdata & ~w_lane_mask) | ((r_wdata << w_shamt) & w_lane_mask);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= '0;
      r_wdata      <= '0;
      r_load_data  <= '0;
      r_fault      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_we        <= i_req_we;
            r_funct3    <= i_req_funct3;
            r_off       <= i_req_addr[OW-1:0];
            r_wdata     <= i_req_wdata;
            r_load_data <= '0;
            if (w_illegal || w_misaligned) begin
              r_fault <= 1'b1;
              r_state <= RESP;
            end else begin
              r_fault    <= 1'b0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {i_req_addr[XLEN-1:OW], {OW{1'b0}}};
              if (w_full_store) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= i_req_wdata;
                r_state     <= WR;
              end else begin
                r_mem_we <= 1'b0;
                r_state  <= RD;
              end
            end
          end
        end
        RD: begin
          if (i_mem_ack) begin
            if (r_we) begin
              r_mem_wdata <= w_merged;
              r_mem_we    <= 1'b1;
              r_state     <= WR;
            end else begin
              r_load_data <= w_load_data;
              r_mem_req   <= 1'b0;
              r_state     <= RESP;
            end
          end
        end
        WR: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_load_data;
          r_resp_fault <= r_fault;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl at XLEN=32 with a one-word memory model at 0x100.
// Inputs change and outputs are sampled 1ns after the rising edge; the memory model acts 2ns after it.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;

  logic [31:0] mem_word = 32'h8899AABB;
  int          ack_delay = 0;
  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;
  int          wait_cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          req_cycles = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;

  int checks = 0;
  int failures = 0;

  lsu_ctrl #(.XLEN(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_fault (resp_fault),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_word;

  // Memory model: decides the ack for the coming edge and logs the access it completes.
  always @(posedge clk) begin
    #2;
    if (mem_req) req_cycles++;
    if (force_ack) begin
      mem_ack = 1'b1;
    end else if (mem_req && ack_en) begin
      if (wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        wait_cnt  = 0;
        last_addr = mem_addr;
        if (mem_we) begin
          wr_count++;
          last_wdata = mem_wdata;
          mem_word   = mem_wdata;
        end else begin
          rd_count++;
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Issues one request and returns the accept-to-resp_valid latency in cycles (-1 on timeout).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int cycles,
                        output logic [31:0] rdata, output logic fault);
    int n;
    cycles = -1;
    rdata  = 32'hDEAD_BEEF;
    fault  = 1'bx;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) begin
        cycles = k;
        rdata  = resp_rdata;
        fault  = resp_fault;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (resp_fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_fault: got %b expected 0", resp_fault); end
    checks++; if ({mem_req, mem_we} !== 2'b00) begin failures++; $display("[TB] FAIL reset_mem_ctl: got %b expected 00", {mem_req, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    int cyc; logic [31:0] rd; logic flt; int rd0, wr0;
    rd0 = rd_count; wr0 = wr_count;
    do_req(1'b0, 3'b000, 32'h103, 32'h0, cyc, rd, flt);
    checks++; if (rd !== 32'hFFFFFF88) begin failures++; $display("[TB] FAIL lb_rdata: got %h expected ffffff88", rd); end
    checks++; if (flt !== 1'b0) begin failures++; $display("[TB] FAIL lb_fault: got %b expected 0", flt); end
    checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL lb_latency: got %0d expected 3", cyc); end
    checks++; if (rd_count - rd0 !== 1 || wr_count - wr0 !== 0) begin failures++; $display("[TB] FAIL lb_accesses: got rd=%0d wr=%0d expected rd=1 wr=0", rd_count - rd0, wr_count - wr0); end
    checks++; if (last_addr !== 32'h100) begin failures++; $display("[TB] FAIL lb_mem_addr: got %h expected 00000100", last_addr); end
    @(posedge clk); #1;
    checks++; if ({resp_valid, resp_fault, resp_rdata} !== 34'h0) begin failures++; $display("[TB] FAIL lb_resp_one_cycle: got v=%b f=%b d=%h expected all 0", resp_valid, resp_fault, resp_rdata); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL lb_ready_after: got %b expected 1", req_ready); end
  endtask

  task automatic test_load_half_wait();
    int cyc; logic [31:0] rd; logic flt; int rc0;
    ack_delay = 2;
    rc0 = req_cycles;
    do_req(1'b0, 3'b101, 32'h102, 32'h0, cyc, rd, flt);
    ack_delay = 0;
    checks++; if (rd !== 32'h00008899) begin failures++; $display("[TB] FAIL lhu_rdata: got %h expected 00008899", rd); end
    checks++; if (req_cycles - rc0 !== 3) begin failures++; $display("[TB] FAIL lhu_req_cycles: got %0d expected 3", req_cycles - rc0); end
    checks++; if (cyc !== 5) begin failures++; $display("[TB] FAIL lhu_latency: got %0d expected 5", cyc); end
  endtask

  task automatic test_store_byte();
    int cyc; logic [31:0] rd; logic flt; int rd0, wr0;
    rd0 = rd_count; wr0 = wr_count;
    do_req(1'b1, 3'b000, 32'h101, 32'h12345655, cyc, rd, flt);
    checks++; if (rd_count - rd0 !== 1 || wr_count - wr0 !== 1) begin failures++; $display("[TB] FAIL sb_accesses: got rd=%0d wr=%0d expected rd=1 wr=1", rd_count - rd0, wr_count - wr0); end
    checks++; if (last_wdata !== 32'h889955BB) begin failures++; $display("[TB] FAIL sb_wdata: got %h expected 889955bb", last_wdata); end
    checks++; if (cyc !== 4) begin failures++; $display("[TB] FAIL sb_latency: got %0d expected 4", cyc); end
    checks++; if (rd !== 32'h0 || flt !== 1'b0) begin failures++; $display("[TB] FAIL sb_resp: got d=%h f=%b expected d=0 f=0", rd, flt); end
  endtask

  task automatic test_store_word();
    int cyc; logic [31:0] rd; logic flt; int rd0, wr0;
    logic [31:0] vec [2];
    vec[0] = 32'hCAFEF00D;
    vec[1] = 32'h8899AABB;
    for (int i = 0; i < 2; i++) begin
      rd0 = rd_count; wr0 = wr_count;
      do_req(1'b1, 3'b010, 32'h100, vec[i], cyc, rd, flt);
      checks++; if (rd_count - rd0 !== 0 || wr_count - wr0 !== 1) begin failures++; $display("[TB] FAIL sw_accesses[%0d]: got rd=%0d wr=%0d expected rd=0 wr=1", i, rd_count - rd0, wr_count - wr0); end
      checks++; if (last_wdata !== vec[i]) begin failures++; $display("[TB] FAIL sw_wdata[%0d]: got %h expected %h", i, last_wdata, vec[i]); end
      checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL sw_latency[%0d]: got %0d expected 3", i, cyc); end
    end
  endtask

  task automatic test_faults();
    int cyc; logic [31:0] rd; logic flt; int rc0;
    logic [2:0]  f3v [2];
    logic [31:0] adv [2];
    f3v[0] = 3'b001; adv[0] = 32'h101;
    f3v[1] = 3'b011; adv[1] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      rc0 = req_cycles;
      do_req(1'b0, f3v[i], adv[i], 32'h0, cyc, rd, flt);
      checks++; if (flt !== 1'b1) begin failures++; $display("[TB] FAIL fault_flag[%0d]: got %b expected 1", i, flt); end
      checks++; if (cyc !== 2) begin failures++; $display("[TB] FAIL fault_latency[%0d]: got %0d expected 2", i, cyc); end
      checks++; if (req_cycles - rc0 !== 0) begin failures++; $display("[TB] FAIL fault_no_mem[%0d]: got %0d mem_req cycles expected 0", i, req_cycles - rc0); end
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL fault_rdata[%0d]: got %h expected 0", i, rd); end
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc; logic [31:0] rd; logic flt; logic seen;
    ack_en     = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_req_held: got %b expected 1", mem_req); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_req_drop: got %b expected 0", mem_req); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_idle: got %b expected 1", req_ready); end
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid || mem_req) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_late_ack: got activity=%b expected 0", seen); end
    ack_en = 1'b1;
    do_req(1'b0, 3'b010, 32'h100, 32'h0, cyc, rd, flt);
    checks++; if (rd !== 32'h8899AABB || flt !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_lw: got d=%h f=%b expected d=8899aabb f=0", rd, flt); end
    checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL rst_mid_lw_latency: got %0d expected 3", cyc); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half_wait();
    test_store_byte();
    test_store_word();
    test_faults();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
